fpga_cfg_loader: RTL

Configuration sequencer for the 4-CLB adder fabric. It accepts a 3-byte configuration frame over a valid/ready byte interface and checks its header and checksum. On a good frame it holds the fabric, commits the 8-bit select word that drives the four 2-bit CLB mux selects, waits a settle interval, then releases the fabric. It sits between the external configuration source and the CLB/routing fabric, and replaces the static bitfile input.

---
 rtl/fpga_cfg_pkg.sv | 35 +++
 rtl/cfg_timer.sv | 49 ++++
 rtl/fpga_cfg_loader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fpga_cfg_pkg.sv
// ----------------------------------------------------------------------------
// fpga_cfg_pkg
//
// Purpose : shared definitions for the configuration loader of the 4-CLB
//           adder fabric: loader state encoding, frame header constant,
//           fabric geometry defaults and the frame checksum helper.
//
// Ports   : none (package).
// ----------------------------------------------------------------------------
package fpga_cfg_pkg;

   // Fabric geometry defaults: four CLBs, each with a 2-bit mux select.
   localparam int NUM_CLB_DEF = 4;
   localparam int SEL_W_DEF   = 2;

   // First byte of every configuration frame.
   localparam logic [7:0] CFG_HDR = 8'hA5;

   // Loader sequencing states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GET_CFG = 3'd1,
      GET_CHK = 3'd2,
      APPLY   = 3'd3,
      SETTLE  = 3'd4,
      RUN     = 3'd5,
      ERROR   = 3'd6
   } cfg_state_t;

   // Checksum byte a well-formed frame must carry after the given CFG byte.
   function automatic logic [7:0] cfg_chk(input logic [7:0] cfg);
      return CFG_HDR ^ cfg;
   endfunction

endpackage : fpga_cfg_pkg

// File: rtl/cfg_timer.sv
// ----------------------------------------------------------------------------
// cfg_timer
//
// Purpose : loadable down-counter with a zero flag. The loader uses one
//           instance for both the inter-byte timeout and the settle
//           interval; the two are never active at the same time.
//
// Ports   :
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset (counter clears to 0)
//   load_i      in   load load_val_i on the next edge (wins over dec_i)
//   load_val_i  in   value to load
//   dec_i       in   decrement on the next edge; saturates at zero
//   zero_o      out  counter currently holds zero
// ----------------------------------------------------------------------------
module cfg_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule : cfg_timer

// File: rtl/fpga_cfg_loader.sv
// ----------------------------------------------------------------------------
// fpga_cfg_loader
//
// Purpose : configuration sequencer for the 4-CLB adder fabric. Receives a
//           3-byte frame {HDR=A5, CFG, CHK=HDR^CFG} over a valid/ready byte
//           interface. A good frame holds the fabric, commits CFG as the
//           select word, waits a settle interval and releases the fabric.
//           A bad checksum or an inter-byte timeout flags an error and leaves
//           the previously committed configuration running.
//
// Ports   :
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   cfg_valid    in   byte-valid strobe
//   cfg_data     in   [7:0] frame byte
//   cfg_ready    out  loader accepts a byte this cycle (decoded from state)
//   sel_bus      out  [NUM_CLB*SEL_W-1:0] committed select word
//   fabric_hold  out  hold CLBs in reset/bypass (decoded from state)
//   cfg_done     out  valid configuration active, fabric running
//   cfg_error    out  last frame failed (checksum or timeout)
//   cfg_count    out  [7:0] successful commits, wraps 255 -> 0
//
// The select word is expected to be 8 bits wide (NUM_CLB*SEL_W <= 8): it is
// taken from the low bits of the CFG byte.
// ----------------------------------------------------------------------------
module fpga_cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int NUM_CLB    = NUM_CLB_DEF,
   parameter int SEL_W      = SEL_W_DEF,
   parameter int SETTLE_CYC = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cfg_valid,
   input  logic [7:0]                 cfg_data,
   output logic                       cfg_ready,
   output logic [NUM_CLB*SEL_W-1:0]   sel_bus,
   output logic                       fabric_hold,
   output logic                       cfg_done,
   output logic                       cfg_error,
   output logic [7:0]                 cfg_count
);

   localparam int SEL_BITS = NUM_CLB * SEL_W;

   // One timer serves both intervals, so it is sized for the longer one.
   localparam int TMR_MAX = (TIMEOUT > SETTLE_CYC) ? TIMEOUT : SETTLE_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   // The timer is checked for zero before it is decremented, so loading N-1
   // gives exactly N cycles before the zero-driven transition fires.
   localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYC - 1);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   cfg_state_t            state_q,   state_d;
   logic [7:0]            shadow_q,  shadow_d;
   logic [SEL_BITS-1:0]   sel_q,     sel_d;
   logic [7:0]            count_q,   count_d;
   logic                  has_cfg_q, has_cfg_d;
   logic                  done_q;
   logic                  error_q;

   // Timer control
   logic                  tmr_load;
   logic [TMR_W-1:0]      tmr_ld_val;
   logic                  tmr_dec;
   logic                  tmr_zero;

   logic                  accept;
   logic                  is_hdr;

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   // Ready is withdrawn only while a commit is in progress; the source has
   // to hold its byte until the settle interval has elapsed.
   assign cfg_ready = (state_q != APPLY) && (state_q != SETTLE);
   assign accept    = cfg_valid && cfg_ready;
   assign is_hdr    = (cfg_data == CFG_HDR);

   // ------------------------------------------------------------------------
   // Shared interval timer
   // ------------------------------------------------------------------------
   cfg_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_ld_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      sel_d      = sel_q;
      count_d    = count_q;
      has_cfg_d  = has_cfg_q;
      tmr_load   = 1'b0;
      tmr_ld_val = TIMEOUT_LD;
      tmr_dec    = 1'b0;

      unique case (state_q)
         // Waiting states: only a header byte starts a frame, anything else
         // is consumed and dropped. A header arms the inter-byte timeout.
         IDLE, RUN, ERROR: begin
            if (accept && is_hdr) begin
               state_d  = GET_CFG;
               tmr_load = 1'b1;
            end
         end

         GET_CFG: begin
            // An accepted byte takes priority over an expiring timeout.
            if (accept) begin
               shadow_d = cfg_data;
               state_d  = GET_CHK;
               tmr_load = 1'b1;
            end else if (tmr_zero) begin
               state_d = ERROR;
            end else begin
               tmr_dec = 1'b1;
            end
         end

         GET_CHK: begin
            if (accept) begin
               state_d = (cfg_data == cfg_chk(shadow_q)) ? APPLY : ERROR;
            end else if (tmr_zero) begin
               state_d = ERROR;
            end else begin
               tmr_dec = 1'b1;
            end
         end

         // Single-cycle commit: the only place the active select word moves.
         APPLY: begin
            sel_d      = shadow_q[SEL_BITS-1:0];
            count_d    = count_q + 8'd1;
            has_cfg_d  = 1'b1;
            state_d    = SETTLE;
            tmr_load   = 1'b1;
            tmr_ld_val = SETTLE_LD;
         end

         SETTLE: begin
            if (tmr_zero) begin
               state_d = RUN;
            end else begin
               tmr_dec = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         shadow_q  <= 8'h00;
         sel_q     <= '0;
         count_q   <= 8'h00;
         has_cfg_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         sel_q     <= sel_d;
         count_q   <= count_d;
         has_cfg_q <= has_cfg_d;
         // Status flags are registered copies of the state being entered so
         // they line up exactly with the state register.
         done_q    <= (state_d == RUN);
         error_q   <= (state_d == ERROR);
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // Until the first commit there is no meaningful configuration, so the
   // fabric is held regardless of state.
   assign fabric_hold = (state_q == APPLY) || (state_q == SETTLE) || !has_cfg_q;
   assign sel_bus     = sel_q;
   assign cfg_done    = done_q;
   assign cfg_error   = error_q;
   assign cfg_count   = count_q;

endmodule : fpga_cfg_loader
